fetch_stage: RTL and testbench

//  IF stage of the pipelined MIPS core. Owns the PC register and drives the word address of the

---
 rtl/fetch_stage.sv | 150 +++++++++++++++
 tb/tb_fetch_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the pipelined MIPS core.
// Owns the fetch PC, drives the combinational instruction-memory word address,
// and registers each fetched instruction with its PC+4 into the IF/ID register.
// Handles stall, flush and branch/jump redirect. Small BOOT/RUN/HALT controller;
// HALT is entered when the PC leaves the instruction-memory range.
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   stall_f, stall_d, flush_d hazard-unit controls (hold PC, hold IF/ID, bubble IF/ID)
//   redirect, redirect_pc     taken branch/jump and its byte target
//   imem_a, imem_rd           instruction memory word address / read data (combinational)
//   pc_f                      current fetch PC
//   instr_d, pcplus4_d        IF/ID instruction and PC+4
//   valid_d                   IF/ID holds a real instruction
//   fault, misalign           sticky status: PC out of range / misaligned redirect seen
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ADDR_BITS = 6,
  parameter logic [31:0] NOP       = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 stall_f,
  input  logic                 stall_d,
  input  logic                 flush_d,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  output logic [ADDR_BITS-1:0] imem_a,
  input  logic [31:0]          imem_rd,
  output logic [31:0]          pc_f,
  output logic [31:0]          instr_d,
  output logic [31:0]          pcplus4_d,
  output logic                 valid_d,
  output logic                 fault,
  output logic                 misalign
);

  localparam int unsigned HI_LSB = ADDR_BITS + 2;

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcplus4;
    logic        valid;
  } ifid_t;

  localparam ifid_t BUBBLE = {NOP, 32'd0, 1'b0};

  state_t      state_q, state_n;
  ifid_t       ifid_q, ifid_n;
  logic [31:0] pc_n;
  logic        fault_n, misalign_n;

  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        in_range;
  logic        target_in_range;

  // Word address straight from the PC; the only combinational output path.
  assign imem_a          = pc_f[ADDR_BITS+1:2];
  assign pc_plus4        = pc_f + 32'd4;
  assign target          = {redirect_pc[31:2], 2'b00};
  assign in_range        = (pc_f >> HI_LSB) == 32'd0;
  assign target_in_range = (target >> HI_LSB) == 32'd0;

  assign instr_d   = ifid_q.instr;
  assign pcplus4_d = ifid_q.pcplus4;
  assign valid_d   = ifid_q.valid;

  // State, PC, IF/ID and status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= BOOT;
      pc_f     <= RESET_PC;
      ifid_q   <= BUBBLE;
      fault    <= 1'b0;
      misalign <= 1'b0;
    end else begin
      state_q  <= state_n;
      pc_f     <= pc_n;
      ifid_q   <= ifid_n;
      fault    <= fault_n;
      misalign <= misalign_n;
    end
  end

  // Next-state and next-register values.
  always_comb begin
    state_n    = state_q;
    pc_n       = pc_f;
    ifid_n     = ifid_q;
    fault_n    = fault;
    misalign_n = misalign;

    // Misaligned targets are recorded in every state but BOOT.
    if (state_q != BOOT && redirect && redirect_pc[1:0] != 2'b00) begin
      misalign_n = 1'b1;
    end

    case (state_q)
      BOOT: begin
        ifid_n  = BUBBLE;
        state_n = RUN;
      end

      RUN: begin
        if (redirect) begin
          pc_n = target;
        end else if (!stall_f) begin
          pc_n = pc_plus4;
        end

        if (flush_d) begin
          ifid_n = BUBBLE;
        end else if (stall_d) begin
          ifid_n = ifid_q;
        end else if (in_range) begin
          ifid_n = {imem_rd, pc_plus4, 1'b1};
        end else begin
          ifid_n = BUBBLE;
        end

        // Fetching outside imem without a pending redirect stops the stage.
        if (!in_range && !redirect) begin
          state_n = HALT;
          fault_n = 1'b1;
        end
      end

      HALT: begin
        if (flush_d || !stall_d) begin
          ifid_n = BUBBLE;
        end
        // Only a redirect can move the PC; an in-range target resumes fetching.
        if (redirect) begin
          pc_n = target;
          if (target_in_range) begin
            state_n = RUN;
          end
        end
      end

      default: begin
        state_n = BOOT;
        ifid_n  = BUBBLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus randomized hazard/redirect traffic for
// fetch_stage, checked every cycle against a behavioural model of the IF stage.
module tb_fetch_stage;

  localparam int unsigned ADDR_BITS  = 6;
  localparam int unsigned IMEM_WORDS = 1 << ADDR_BITS;
  localparam logic [31:0] IMEM_BYTES = 32'(4 * IMEM_WORDS);
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] NOP        = 32'h0000_0000;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 stall_f, stall_d, flush_d, redirect;
  logic [31:0]          redirect_pc;
  logic [ADDR_BITS-1:0] imem_a;
  logic [31:0]          imem_rd;
  logic [31:0]          pc_f, instr_d, pcplus4_d;
  logic                 valid_d, fault, misalign;

  logic [31:0] imem [IMEM_WORDS];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [31:0] m_pc, m_instr, m_pp4;
  logic        m_valid, m_fault, m_mis;
  bit          m_boot, m_halt;

  always #5 clk = ~clk;

  assign imem_rd = imem[imem_a];

  fetch_stage #(.RESET_PC(RESET_PC), .ADDR_BITS(ADDR_BITS), .NOP(NOP)) dut (
    .clk(clk), .reset_n(reset_n),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_a(imem_a), .imem_rd(imem_rd),
    .pc_f(pc_f), .instr_d(instr_d), .pcplus4_d(pcplus4_d),
    .valid_d(valid_d), .fault(fault), .misalign(misalign)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] ea;
    ea = m_pc >> 2;
    check({tag, ".pc"},       pc_f,             m_pc);
    check({tag, ".imem_a"},   32'(imem_a),      32'(ea[ADDR_BITS-1:0]));
    check({tag, ".instr"},    instr_d,          m_instr);
    check({tag, ".pcplus4"},  pcplus4_d,        m_pp4);
    check({tag, ".valid"},    32'(valid_d),     32'(m_valid));
    check({tag, ".fault"},    32'(fault),       32'(m_fault));
    check({tag, ".misalign"}, 32'(misalign),    32'(m_mis));
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_instr = NOP; m_pp4 = 32'd0; m_valid = 1'b0;
    m_fault = 1'b0; m_mis = 1'b0; m_boot = 1'b1; m_halt = 1'b0;
  endtask

  task automatic model_bubble();
    m_instr = NOP; m_pp4 = 32'd0; m_valid = 1'b0;
  endtask

  // One clock of IF-stage behaviour from the current inputs.
  task automatic model_step();
    logic [31:0] tgt;
    bit          fetch_ok;
    tgt      = redirect_pc & 32'hFFFF_FFFC;
    fetch_ok = m_pc < IMEM_BYTES;
    if (m_boot) begin
      model_bubble();
      m_boot = 1'b0;
      return;
    end
    if (redirect && (redirect_pc % 4) != 0) m_mis = 1'b1;
    if (!m_halt) begin
      if (flush_d) model_bubble();
      else if (!stall_d) begin
        if (fetch_ok) begin
          m_instr = imem[m_pc / 4]; m_pp4 = m_pc + 32'd4; m_valid = 1'b1;
        end else model_bubble();
      end
      if (!fetch_ok && !redirect) begin
        m_halt = 1'b1; m_fault = 1'b1;
      end
      if (redirect) m_pc = tgt;
      else if (!stall_f) m_pc = m_pc + 32'd4;
    end else begin
      if (flush_d || !stall_d) model_bubble();
      if (redirect) begin
        m_pc = tgt;
        if (tgt < IMEM_BYTES) m_halt = 1'b0;
      end
    end
  endtask

  task automatic idle_inputs();
    stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
  endtask

  // Advance one clock and compare everything just after the edge.
  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    for (int i = 0; i < IMEM_WORDS; i++) imem[i] = 32'h1000_0000 + 32'(i);
    idle_inputs();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");

    // 1: boot bubble then sequential fetch.
    reset_n = 1'b1;
    tick("boot");
    check("boot.valid_lo", 32'(valid_d), 32'd0);
    for (int i = 0; i < 4; i++) tick("seq");
    check("seq.instr3", instr_d, 32'h1000_0003);
    check("seq.pc", pc_f, 32'h10);

    // 2: combined stall at pc 0x10.
    stall_f = 1'b1; stall_d = 1'b1;
    repeat (3) tick("stall");
    check("stall.pc_held", pc_f, 32'h10);
    check("stall.instr_held", instr_d, 32'h1000_0003);
    idle_inputs();
    tick("stall_rel");
    check("stall_rel.instr", instr_d, 32'h1000_0004);
    check("stall_rel.pc", pc_f, 32'h14);

    // 3: redirect beats stall_f, flush bubbles IF/ID.
    redirect = 1'b1; redirect_pc = 32'h40; flush_d = 1'b1; stall_f = 1'b1;
    tick("redir");
    check("redir.pc", pc_f, 32'h40);
    check("redir.valid", 32'(valid_d), 32'd0);
    idle_inputs();
    tick("redir_next");
    check("redir_next.instr", instr_d, 32'h1000_0010);

    // 4: run off the end of imem, halt, recover.
    for (int i = 0; i < 200 && m_pc != 32'hFC; i++) tick("run");
    check("run.at_fc", pc_f, 32'hFC);
    tick("last");
    check("last.instr", instr_d, 32'h1000_003F);
    check("last.pc", pc_f, 32'h100);
    tick("halt");
    check("halt.fault", 32'(fault), 32'd1);
    check("halt.valid", 32'(valid_d), 32'd0);
    tick("halt2");
    check("halt2.fault", 32'(fault), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h0;
    tick("resume");
    idle_inputs();
    tick("resume_next");
    check("resume.instr", instr_d, 32'h1000_0000);
    check("resume.valid", 32'(valid_d), 32'd1);

    // 5: misaligned redirect is sticky.
    redirect = 1'b1; redirect_pc = 32'h23;
    tick("mis");
    check("mis.pc", pc_f, 32'h20);
    check("mis.flag", 32'(misalign), 32'd1);
    redirect_pc = 32'h44;
    tick("mis2");
    idle_inputs();
    tick("mis3");
    check("mis3.flag", 32'(misalign), 32'd1);

    // 6: asynchronous reset while stalled.
    stall_f = 1'b1; stall_d = 1'b1;
    tick("pre_rst");
    #2 reset_n = 1'b0;
    #1;
    check("arst.pc", pc_f, RESET_PC);
    check("arst.valid", 32'(valid_d), 32'd0);
    check("arst.fault", 32'(fault), 32'd0);
    check("arst.misalign", 32'(misalign), 32'd0);
    model_reset();
    idle_inputs();
    @(posedge clk);
    #1;
    check_all("arst_hold");
    reset_n = 1'b1;

    // Randomized hazard/redirect traffic.
    for (int c = 0; c < 1500; c++) begin
      int r;
      stall_f  = ($urandom_range(0, 99) < 20);
      stall_d  = stall_f && ($urandom_range(0, 1) == 1);
      flush_d  = ($urandom_range(0, 99) < 8);
      redirect = ($urandom_range(0, 99) < 6);
      r = int'($urandom_range(0, 9));
      if (r < 6)      redirect_pc = 32'($urandom_range(0, 63)) << 2;
      else if (r < 8) redirect_pc = 32'($urandom_range(0, 255));
      else            redirect_pc = $urandom;
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
